seg_scan_decoder: RTL and testbench

Receive side of the multiplexed seven-segment display bus: samples the active-low digit-select (AN) and segment (SEG) lines and decodes each segment pattern back to its 4-bit hex code. Reconstructs the displayed multi-digit value and publishes it atomically once per complete scan frame. Used as a loopback monitor in board self-test and as a checker in display-path testbenches, sitting beside the display driver on the same clock.

---
 rtl/seg_pkg.sv | 27 ++
 rtl/seg_pattern_decode.sv | 35 +++
 rtl/seg_scan_decoder.sv | 167 ++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants for seven-segment bus checkers: active-low g..a patterns, defaults, FSM states.
package seg_pkg;

  localparam int DIGITS_DEFAULT = 8;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h18;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  typedef logic [0:0] state_t;
  localparam state_t ACQ  = 1'b0;
  localparam state_t LOCK = 1'b1;

endpackage

// File: rtl/seg_pattern_decode.sv
// Active-low g..a segment pattern to hex code; legal=0 for any non-hex glyph.
// Purely combinational, no backpressure.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       legal,
  output logic [3:0] code
);

  always_comb begin
    legal = 1'b1;
    code  = 4'h0;
    case (pattern)
      SEG_0:   code = 4'h0;
      SEG_1:   code = 4'h1;
      SEG_2:   code = 4'h2;
      SEG_3:   code = 4'h3;
      SEG_4:   code = 4'h4;
      SEG_5:   code = 4'h5;
      SEG_6:   code = 4'h6;
      SEG_7:   code = 4'h7;
      SEG_8:   code = 4'h8;
      SEG_9:   code = 4'h9;
      SEG_A:   code = 4'hA;
      SEG_B:   code = 4'hB;
      SEG_C:   code = 4'hC;
      SEG_D:   code = 4'hD;
      SEG_E:   code = 4'hE;
      SEG_F:   code = 4'hF;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the multi-digit value shown on a muxed 7-seg bus and publishes it once per scan frame.
// Sample reg 1 cycle, publish 1 cycle after the last commit; passive monitor, no backpressure.
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int                DIGITS      = DIGITS_DEFAULT,
  parameter logic [DIGITS-1:0] ACTIVE_MASK = DIGITS'(8'h03),
  parameter int                STABLE_CNT  = 4,
  parameter int                TIMEOUT     = 2**20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     AN,
  input  logic [7:0]            SEG,
  output logic [4*DIGITS-1:0]   value,
  output logic [DIGITS-1:0]     dp,
  output logic                  valid,
  output logic                  frame_done,
  output logic                  changed,
  output logic                  err_seg,
  output logic                  err_an
);

  localparam int IW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW  = $clog2(STABLE_CNT + 1);
  localparam int TW  = $clog2(TIMEOUT + 1);

  logic [DIGITS-1:0]   an_q;
  logic [7:0]          seg_q;
  logic                blank, single, multi;
  logic [IW-1:0]       idx;
  logic                legal;
  logic [3:0]          code;
  logic                seg_dp;

  logic [IW-1:0]       last_idx;
  logic [3:0]          last_code;
  logic                last_dp;
  logic [CW-1:0]       cnt;
  logic                run_ok, match, commit, frame;

  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [DIGITS-1:0]   seen, seen_nxt;
  logic [TW-1:0]       idle;
  state_t              state;

  // Idle bus is all-ones, so the sampler resets to "blank" rather than a phantom multi-select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q  <= '1;
      seg_q <= '1;
    end else begin
      an_q  <= AN;
      seg_q <= SEG;
    end
  end

  always_comb begin
    blank = &an_q;
    single = $onehot(~an_q);
    multi = !blank && !single;
    idx = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (!an_q[k]) idx = IW'(k);
    end
  end

  seg_pattern_decode u_decode (
    .pattern (seg_q[6:0]),
    .legal   (legal),
    .code    (code)
  );

  assign seg_dp = ~seg_q[7];
  assign run_ok = single && legal;
  assign match  = (idx == last_idx) && (code == last_code) && (seg_dp == last_dp);
  // Only the transition into STABLE_CNT commits; a saturated run stays quiet.
  assign commit = run_ok && match && (cnt == CW'(STABLE_CNT - 1));
  assign frame  = ((seen & ACTIVE_MASK) == ACTIVE_MASK);

  always_comb begin
    seen_nxt = frame ? '0 : seen;
    if (commit) seen_nxt[idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      last_idx  <= '0;
      last_code <= '0;
      last_dp   <= 1'b0;
    end else if (run_ok) begin
      if (!match) begin
        cnt       <= CW'(1);
        last_idx  <= idx;
        last_code <= code;
        last_dp   <= seg_dp;
      end else if (cnt != CW'(STABLE_CNT)) begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      seen       <= '0;
    end else begin
      seen <= seen_nxt;
      if (commit) begin
        shadow_val[idx*4 +: 4] <= code;
        shadow_dp[idx]         <= seg_dp;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value      <= '0;
      dp         <= '0;
      frame_done <= 1'b0;
      changed    <= 1'b0;
    end else begin
      frame_done <= frame;
      changed    <= frame && (state == LOCK) && ((shadow_val != value) || (shadow_dp != dp));
      if (frame) begin
        value <= shadow_val;
        dp    <= shadow_dp;
      end
    end
  end

  // A commit in the same cycle as expiry keeps the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACQ;
      idle  <= '0;
    end else if (state == ACQ) begin
      idle <= '0;
      if (frame) state <= LOCK;
    end else if (commit) begin
      idle <= '0;
    end else if (idle == TW'(TIMEOUT - 1)) begin
      idle  <= '0;
      state <= ACQ;
    end else begin
      idle <= idle + TW'(1);
    end
  end

  assign valid = (state == LOCK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_seg <= 1'b0;
      err_an  <= 1'b0;
    end else begin
      if (multi) err_an <= 1'b1;
      if (single && !legal) err_seg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder: lock, change detect, short dwell, errors, timeout, reset.
module tb_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  AN;
  logic [7:0]  SEG;
  logic [31:0] value;
  logic [7:0]  dp;
  logic        valid, frame_done, changed, err_seg, err_an;

  int checks   = 0;
  int failures = 0;
  int frames   = 0;
  int changes  = 0;
  int lone_chg = 0;

  always #5 clk = ~clk;

  seg_scan_decoder #(
    .DIGITS      (8),
    .ACTIVE_MASK (8'h03),
    .STABLE_CNT  (4),
    .TIMEOUT     (64)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .AN         (AN),
    .SEG        (SEG),
    .value      (value),
    .dp         (dp),
    .valid      (valid),
    .frame_done (frame_done),
    .changed    (changed),
    .err_seg    (err_seg),
    .err_an     (err_an)
  );

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) frames++;
      if (changed) changes++;
      if (changed && !frame_done) lone_chg++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] an, input logic [7:0] seg, input int n);
    AN  = an;
    SEG = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pair(input logic [7:0] seg0, input logic [7:0] seg1, input int d1);
    drive(8'hFE, seg0, 8);
    drive(8'hFD, seg1, d1);
  endtask

  initial begin
    rst = 1'b1;
    AN  = 8'hFF;
    SEG = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_value", value, 32'h0);
    check("rst_dp", {24'h0, dp}, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_changed", {31'h0, changed}, 32'h0);
    check("rst_err_seg", {31'h0, err_seg}, 32'h0);
    check("rst_err_an", {31'h0, err_an}, 32'h0);
    rst = 1'b0;

    // digit 1 never stays long enough to commit
    for (int p = 0; p < 4; p++) pair(8'h92, 8'hF9, 3);
    drive(8'hFF, 8'hFF, 4);
    check("short_frames", frames, 32'd0);
    check("short_valid", {31'h0, valid}, 32'h0);
    check("short_value", value, 32'h0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int p = 0; p < 4; p++) pair(8'h92, 8'hF9, 8);
    drive(8'hFF, 8'hFF, 4);
    check("lock_frames", frames, 32'd4);
    check("lock_valid", {31'h0, valid}, 32'h1);
    check("lock_value", value, 32'h0000_0015);
    check("lock_dp", {24'h0, dp}, 32'h0);
    check("lock_changed", changes, 32'd0);

    for (int p = 0; p < 3; p++) pair(8'hA4, 8'hF9, 8);
    drive(8'hFF, 8'hFF, 4);
    check("chg_frames", frames, 32'd7);
    check("chg_value", value, 32'h0000_0012);
    check("chg_count", changes, 32'd1);
    check("chg_coincident", lone_chg, 32'd0);

    drive(8'hFC, 8'h92, 1);
    drive(8'hFF, 8'hFF, 3);
    check("err_an_set", {31'h0, err_an}, 32'h1);
    check("err_an_no_seg", {31'h0, err_seg}, 32'h0);
    drive(8'hFF, 8'hFF, 10);
    check("err_an_sticky", {31'h0, err_an}, 32'h1);

    drive(8'hFE, 8'hFF, 5);
    drive(8'hFF, 8'hFF, 3);
    check("err_seg_set", {31'h0, err_seg}, 32'h1);
    check("err_seg_value", value, 32'h0000_0012);
    check("err_seg_frames", frames, 32'd7);
    check("err_an_still", {31'h0, err_an}, 32'h1);

    // last commit lands mid-slot of digit 1, so ~53 idle cycles at the first probe
    for (int p = 0; p < 2; p++) pair(8'h92, 8'hF9, 8);
    drive(8'hFF, 8'hFF, 50);
    check("to_valid_before", {31'h0, valid}, 32'h1);
    check("to_value_before", value, 32'h0000_0015);
    check("to_changes", changes, 32'd2);
    drive(8'hFF, 8'hFF, 20);
    check("to_valid_after", {31'h0, valid}, 32'h0);
    check("to_value_hold", value, 32'h0000_0015);
    check("to_frames", frames, 32'd9);

    // first frame after re-lock must not flag a change even though the value differs
    pair(8'hA4, 8'hF9, 8);
    drive(8'hFF, 8'hFF, 4);
    check("relock_valid", {31'h0, valid}, 32'h1);
    check("relock_value", value, 32'h0000_0012);
    check("relock_no_changed", changes, 32'd2);
    check("relock_frames", frames, 32'd10);

    drive(8'hFE, 8'h92, 8);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_value", value, 32'h0);
    check("midrst_valid", {31'h0, valid}, 32'h0);
    check("midrst_dp", {24'h0, dp}, 32'h0);
    check("midrst_err_an", {31'h0, err_an}, 32'h0);
    check("midrst_err_seg", {31'h0, err_seg}, 32'h0);
    check("midrst_frame_done", {31'h0, frame_done}, 32'h0);
    rst = 1'b0;

    for (int p = 0; p < 2; p++) pair(8'h92, 8'hF9, 8);
    drive(8'hFF, 8'hFF, 4);
    check("post_valid", {31'h0, valid}, 32'h1);
    check("post_value", value, 32'h0000_0015);
    check("post_frames", frames, 32'd12);
    check("post_changes", changes, 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
